// File: rtl/coincidence_counter.sv
// Multi-channel MPPC hit counter with a windowed coincidence detector.
// Live counters are snapshotted into shadow registers for a registered readout mux.
module coincidence_counter #(
  parameter int WINDOW_CYCLES = 8,
  parameter int CNT_W         = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       CH_IN,
  input  logic [7:0]       CH_MASK,
  input  logic             SNAP,
  input  logic [3:0]       RD_SEL,
  output logic [CNT_W-1:0] RD_DATA,
  output logic             SNAP_DONE,
  output logic             COINC,
  output logic [7:0]       HIT
);

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]       TIMER_LOAD = 8'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  logic [7:0] sync1_reg;
  logic [7:0] sync2_reg;
  logic [7:0] prev_reg;
  logic [7:0] hit_reg;

  state_t     state_reg, state_next;
  logic [7:0] mask_reg, mask_next;
  logic [7:0] seen_reg, seen_next;
  logic [7:0] timer_reg, timer_next;
  logic       coinc_reg, coinc_next;

  logic             snap_done_reg;
  logic [CNT_W-1:0] rd_data_reg, rd_data_next;

  logic [8:0]                  inc;
  logic [8:0][CNT_W-1:0]       live_all;
  logic [8:0][CNT_W-1:0]       shadow_all;

  // Flops preset to 1 so a channel already high at reset release is not seen as an edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_reg <= 8'hFF;
      sync2_reg <= 8'hFF;
      prev_reg  <= 8'hFF;
      hit_reg   <= 8'h00;
    end else begin
      sync1_reg <= CH_IN;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      hit_reg   <= sync2_reg & ~prev_reg;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      mask_reg  <= 8'h00;
      seen_reg  <= 8'h00;
      timer_reg <= 8'h00;
      coinc_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      mask_reg  <= mask_next;
      seen_reg  <= seen_next;
      timer_reg <= timer_next;
      coinc_reg <= coinc_next;
    end
  end

  // Completion is judged on the registered seen set, so it outranks the timer expiring.
  always_comb begin
    state_next = state_reg;
    mask_next  = mask_reg;
    seen_next  = seen_reg;
    timer_next = timer_reg;
    coinc_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if ((CH_MASK != 8'h00) && ((hit_reg & CH_MASK) != 8'h00)) begin
          state_next = OPEN;
          mask_next  = CH_MASK;
          seen_next  = hit_reg & CH_MASK;
          timer_next = TIMER_LOAD;
        end
      end
      OPEN: begin
        seen_next = seen_reg | (hit_reg & mask_reg);
        if (seen_reg == mask_reg) begin
          coinc_next = 1'b1;
          state_next = HOLDOFF;
        end else if (timer_reg == 8'h00) begin
          state_next = IDLE;
        end else begin
          timer_next = timer_reg - 8'd1;
        end
      end
      HOLDOFF: begin
        if ((sync2_reg & mask_reg) == 8'h00) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign inc = {coinc_reg, hit_reg};

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_cnt
      logic [CNT_W-1:0] live_reg;
      logic [CNT_W-1:0] shadow_reg;

      // An increment landing on SNAP belongs to the next interval, not the shadow.
      always_ff @(posedge CLK) begin
        if (RST) begin
          live_reg   <= '0;
          shadow_reg <= '0;
        end else if (SNAP) begin
          shadow_reg <= live_reg;
          live_reg   <= inc[gi] ? CNT_ONE : '0;
        end else if (inc[gi] && (live_reg != CNT_MAX)) begin
          live_reg <= live_reg + CNT_ONE;
        end
      end

      assign live_all[gi]   = live_reg;
      assign shadow_all[gi] = shadow_reg;
    end
  endgenerate

  // Bypass the live value on SNAP so RD_DATA already shows the new shadow with SNAP_DONE.
  always_comb begin
    rd_data_next = '0;
    if (RD_SEL <= 4'd8) begin
      rd_data_next = SNAP ? live_all[RD_SEL] : shadow_all[RD_SEL];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_data_reg   <= '0;
      snap_done_reg <= 1'b0;
    end else begin
      rd_data_reg   <= rd_data_next;
      snap_done_reg <= SNAP;
    end
  end

  assign RD_DATA   = rd_data_reg;
  assign SNAP_DONE = snap_done_reg;
  assign COINC     = coinc_reg;
  assign HIT       = hit_reg;

endmodule

// File: tb/tb_coincidence_counter.sv
// Randomised and directed bench for coincidence_counter: a cycle-indexed reference
// model queues expected events, and a negedge monitor pops and compares them.
module tb_coincidence_counter;

  localparam int W    = 8;
  localparam int CW   = 8;      // narrow counters so saturation is reachable quickly
  localparam int MAXC = 20000;
  localparam logic [CW-1:0] CMAX = '1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [7:0]    CH_IN = 8'h00;
  logic [7:0]    CH_MASK = 8'h00;
  logic          SNAP = 1'b0;
  logic [3:0]    RD_SEL = 4'h0;
  logic [CW-1:0] RD_DATA;
  logic          SNAP_DONE;
  logic          COINC;
  logic [7:0]    HIT;

  coincidence_counter #(.WINDOW_CYCLES(W), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .CH_IN(CH_IN), .CH_MASK(CH_MASK), .SNAP(SNAP),
    .RD_SEL(RD_SEL), .RD_DATA(RD_DATA), .SNAP_DONE(SNAP_DONE), .COINC(COINC), .HIT(HIT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { int cyc; int ch; } hit_ev_t;
  typedef struct { int cyc; logic [CW-1:0] data; } rd_ev_t;

  hit_ev_t hit_q[$];
  int      coinc_q[$];
  int      snap_q[$];
  rd_ev_t  rd_q[$];

  int compared = 0;
  int mismatched = 0;

  // Reference model: s_hist[j] = CH_IN sampled at rising edge j.
  logic [7:0]    s_hist [0:MAXC+3];
  int            m_mode = 0;           // 0 idle, 1 window open, 2 holdoff
  logic [7:0]    m_mlat = 8'h00;
  logic [7:0]    m_seen = 8'h00;
  int            m_opened = 0;
  bit            m_coinc_now = 1'b0;
  bit            m_last_rst = 1'b1;
  logic [CW-1:0] m_live [9];
  logic [CW-1:0] m_shadow [9];

  function automatic logic [7:0] s_at(int j);
    return (j < 0) ? 8'hFF : s_hist[j];
  endfunction

  task automatic model_step(int k, logic [7:0] in, logic [7:0] mask, bit snap,
                            logic [3:0] sel, bit rst);
    logic [7:0]    hit;
    logic [7:0]    lvl;
    logic [8:0]    inc;
    bit            coinc_next;
    logic [CW-1:0] rdv;
    hit = m_last_rst ? 8'h00 : (s_at(k-2) & ~s_at(k-3));
    lvl = s_at(k-1);
    if (k >= 1) for (int n = 0; n < 8; n++) if (hit[n]) hit_q.push_back('{k, n});
    s_hist[k+1] = in;
    m_last_rst = rst;
    if (rst) begin
      s_hist[k+1] = 8'hFF;
      s_hist[k]   = 8'hFF;
      if (k >= 1) s_hist[k-1] = 8'hFF;
      m_mode = 0; m_seen = 8'h00; m_mlat = 8'h00; m_coinc_now = 1'b0;
      for (int i = 0; i < 9; i++) begin m_live[i] = '0; m_shadow[i] = '0; end
      rd_q.push_back('{k+1, '0});
      return;
    end
    inc = {m_coinc_now, hit};
    if (snap) begin
      for (int i = 0; i < 9; i++) begin
        m_shadow[i] = m_live[i];
        m_live[i]   = inc[i] ? CW'(1) : CW'(0);
      end
      snap_q.push_back(k+1);
    end else begin
      for (int i = 0; i < 9; i++) if (inc[i] && m_live[i] != CMAX) m_live[i] = m_live[i] + CW'(1);
    end
    rdv = (sel <= 4'd8) ? m_shadow[sel] : '0;
    rd_q.push_back('{k+1, rdv});
    coinc_next = 1'b0;
    case (m_mode)
      0: if (mask != 8'h00 && (hit & mask) != 8'h00) begin
           m_mode = 1; m_mlat = mask; m_seen = hit & mask; m_opened = k;
         end
      1: if (m_seen == m_mlat) begin
           coinc_next = 1'b1; m_mode = 2;
         end else if (k - m_opened >= W) begin
           m_mode = 0;
         end else begin
           m_seen = m_seen | (hit & m_mlat);
         end
      default: if ((lvl & m_mlat) == 8'h00) m_mode = 0;
    endcase
    m_coinc_now = coinc_next;
    if (coinc_next) coinc_q.push_back(k+1);
  endtask

  task automatic step(logic [7:0] in, bit snap, bit rst);
    CH_IN = in; SNAP = snap; RST = rst;
    model_step(cyc, in, CH_MASK, snap, RD_SEL, rst);
    @(posedge CLK); #1;
  endtask

  task automatic idle(int n, logic [7:0] in);
    repeat (n) step(in, 1'b0, 1'b0);
  endtask

  task automatic sweep_sel();
    for (int i = 0; i < 16; i++) begin RD_SEL = i[3:0]; idle(1, CH_IN); end
  endtask

  always @(negedge CLK) begin
    rd_ev_t e;
    if (cyc >= 1) begin
      for (int n = 0; n < 8; n++) if (HIT[n]) begin
        compared++;
        if (hit_q.size() != 0 && hit_q[0].cyc == cyc && hit_q[0].ch == n) void'(hit_q.pop_front());
        else begin
          mismatched++;
          $display("FAIL hit_spurious ch%0d cycle %0d: got HIT=1, required 0", n, cyc);
        end
      end
      while (hit_q.size() != 0 && hit_q[0].cyc <= cyc) begin
        compared++; mismatched++;
        $display("FAIL hit_missing ch%0d cycle %0d: got HIT=0, required 1", hit_q[0].ch, hit_q[0].cyc);
        void'(hit_q.pop_front());
      end
      if (COINC) begin
        compared++;
        if (coinc_q.size() != 0 && coinc_q[0] == cyc) begin
          void'(coinc_q.pop_front());
          $display("coinc     cycle %0d ok", cyc);
        end else begin
          mismatched++;
          $display("FAIL coinc_spurious cycle %0d: got COINC=1, required 0", cyc);
        end
      end
      while (coinc_q.size() != 0 && coinc_q[0] <= cyc) begin
        compared++; mismatched++;
        $display("FAIL coinc_missing cycle %0d: got COINC=0, required 1", coinc_q[0]);
        void'(coinc_q.pop_front());
      end
      if (SNAP_DONE) begin
        compared++;
        if (snap_q.size() != 0 && snap_q[0] == cyc) begin
          void'(snap_q.pop_front());
          $display("snap_done cycle %0d sel=%0d rd_data=%0d", cyc, RD_SEL, RD_DATA);
        end else begin
          mismatched++;
          $display("FAIL snap_done_spurious cycle %0d: got SNAP_DONE=1, required 0", cyc);
        end
      end
      while (snap_q.size() != 0 && snap_q[0] <= cyc) begin
        compared++; mismatched++;
        $display("FAIL snap_done_missing cycle %0d: got SNAP_DONE=0, required 1", snap_q[0]);
        void'(snap_q.pop_front());
      end
      while (rd_q.size() != 0 && rd_q[0].cyc <= cyc) begin
        e = rd_q.pop_front();
        compared++;
        if (e.cyc != cyc || RD_DATA !== e.data) begin
          mismatched++;
          $display("FAIL rd_data cycle %0d: got %0d, required %0d (for cycle %0d)", cyc, RD_DATA, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] flip;
    #1;
    // All channels held high through reset release: no HIT, counts stay zero.
    repeat (4) step(8'hFF, 1'b0, 1'b1);
    idle(6, 8'hFF);
    idle(4, 8'h00);
    step(8'h00, 1'b1, 1'b0);
    sweep_sel();

    // Two-cycle pulse on channel 3, then snapshot and read it back.
    step(8'h08, 1'b0, 1'b0); step(8'h08, 1'b0, 1'b0);
    idle(6, 8'h00);
    RD_SEL = 4'd3; step(8'h00, 1'b1, 1'b0); idle(3, 8'h00);

    // CH1 five cycles after CH0: inside the window.
    CH_MASK = 8'h03;
    step(8'h01, 1'b0, 1'b0); step(8'h01, 1'b0, 1'b0); idle(3, 8'h00);
    step(8'h02, 1'b0, 1'b0); step(8'h02, 1'b0, 1'b0); idle(10, 8'h00);
    RD_SEL = 4'd8; step(8'h00, 1'b1, 1'b0); idle(3, 8'h00);

    // CH1 eight cycles after CH0: window expired.
    step(8'h01, 1'b0, 1'b0); step(8'h01, 1'b0, 1'b0); idle(6, 8'h00);
    step(8'h02, 1'b0, 1'b0); step(8'h02, 1'b0, 1'b0); idle(12, 8'h00);
    step(8'h00, 1'b1, 1'b0); sweep_sel();

    // Both held after a coincidence; toggling CH0 must not retrigger.
    idle(6, 8'h03);
    repeat (3) begin idle(2, 8'h02); idle(4, 8'h03); end
    idle(10, 8'h00);
    step(8'h00, 1'b1, 1'b0); sweep_sel();

    // Saturate channel 5, then a HIT landing exactly on SNAP.
    CH_MASK = 8'h00;
    repeat (CMAX + 2) begin step(8'h20, 1'b0, 1'b0); step(8'h00, 1'b0, 1'b0); end
    idle(5, 8'h00);
    RD_SEL = 4'd5; step(8'h00, 1'b1, 1'b0); idle(3, 8'h00);
    step(8'h20, 1'b0, 1'b0); step(8'h00, 1'b0, 1'b0); step(8'h00, 1'b0, 1'b0);
    step(8'h00, 1'b1, 1'b0); idle(4, 8'h00);
    step(8'h00, 1'b1, 1'b0); idle(3, 8'h00);

    // Reset in the middle of an open window.
    CH_MASK = 8'h03;
    step(8'h01, 1'b0, 1'b0); step(8'h01, 1'b0, 1'b0); idle(3, 8'h00);
    step(8'h00, 1'b0, 1'b1); idle(4, 8'h00);
    step(8'h02, 1'b0, 1'b0); step(8'h02, 1'b0, 1'b0); idle(12, 8'h00);
    step(8'h03, 1'b0, 1'b0); step(8'h03, 1'b0, 1'b0); idle(8, 8'h00);
    RD_SEL = 4'd8; step(8'h00, 1'b1, 1'b0); idle(3, 8'h00);

    // Random traffic.
    for (int t = 0; t < 3000; t++) begin
      if (t % 64 == 0) begin
        case ($urandom_range(0, 4))
          0: CH_MASK = 8'h03;
          1: CH_MASK = 8'h01;
          2: CH_MASK = 8'h0F;
          3: CH_MASK = 8'h00;
          default: CH_MASK = 8'($urandom_range(0, 255));
        endcase
      end
      RD_SEL = 4'($urandom_range(0, 15));
      flip = 8'h00;
      for (int b = 0; b < 8; b++) flip[b] = ($urandom_range(0, 3) == 0);
      step(CH_IN ^ flip, $urandom_range(0, 19) == 0, $urandom_range(0, 999) == 0);
    end
    idle(12, 8'h00);
    @(negedge CLK); #1;

    while (hit_q.size() != 0) begin
      compared++; mismatched++;
      $display("FAIL hit_leftover ch%0d cycle %0d: got none, required HIT", hit_q[0].ch, hit_q[0].cyc);
      void'(hit_q.pop_front());
    end
    while (coinc_q.size() != 0) begin
      compared++; mismatched++;
      $display("FAIL coinc_leftover cycle %0d: got none, required COINC", coinc_q[0]);
      void'(coinc_q.pop_front());
    end
    while (snap_q.size() != 0) begin
      compared++; mismatched++;
      $display("FAIL snap_leftover cycle %0d: got none, required SNAP_DONE", snap_q[0]);
      void'(snap_q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
